writeback_queue: RTL
====================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write requests; SHALL be a power of two and at least 2.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  producer offers a write request.
REQ-005 in_ready  output  1  queue can accept a request this cycle.
REQ-006 in_register  input  5  destination register index of offered request.
REQ-007 in_data  input  32  data of offered request.
REQ-008 stall  input  1  inhibits draining into the register file this cycle.
REQ-009 reg_write  output  1  write strobe to the register file.
REQ-010 write_register  output  5  register file write index.
REQ-011 write_data  output  32  register file write data.
REQ-012 lookup_register_1 / lookup_register_2  input  5 each  read indices under forwarding check.
REQ-013 lookup_hit_1 / lookup_hit_2  output  1 each  a pending write exists for that index.
REQ-014 lookup_data_1 / lookup_data_2  output  32 each  youngest pending data for that index.
REQ-015 count  output  clog2(DEPTH)+1  number of queued entries, excluding the output stage.

Function
REQ-016 Queue SHALL be a FIFO of DEPTH entries, each {register, data}, with head/tail pointers wrapping modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH), derived from registered state only; no push while full, even if a pop occurs the same edge.
REQ-018 Push SHALL occur on an edge where in_valid and in_ready are both 1; request SHALL be enqueued at tail and count incremented.
REQ-019 Accepted request with in_register = 0 SHALL complete the handshake but be discarded: not enqueued, count unchanged.
REQ-020 Pop: on each edge with stall = 0 and count > 0, head SHALL be removed and loaded into the output stage; reg_write SHALL be 1 with write_register/write_data = head for exactly the following cycle.
REQ-021 On each edge with stall = 1 or count = 0, reg_write SHALL become 0; write_register/write_data SHALL hold their previous values.
REQ-022 No bypass: an entry pushed into an empty queue at edge N SHALL be popped no earlier than edge N+1, giving reg_write = 1 in the cycle after N+1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-024 Back-to-back pops SHALL keep reg_write = 1 in consecutive cycles, one entry per cycle.
REQ-025 Lookup SHALL be combinational over all valid queue entries plus the output stage while reg_write = 1.
REQ-026 Lookup priority SHALL be youngest queue entry first, then older entries, then the output stage.
REQ-027 lookup_register = 0 SHALL give hit 0, data 0; any miss SHALL give data 0.
REQ-028 Stall SHALL not block pushes; the queue fills to DEPTH and in_ready drops to 0.

Reset
REQ-029 reset_n low SHALL immediately clear pointers, count, reg_write, write_register and write_data to 0; all queued entries are lost.
REQ-030 After reset deassertion, in_ready SHALL be 1 and the lookup hit outputs SHALL be 0.
REQ-031 Reset asserted mid-drain SHALL drop reg_write to 0 asynchronously, with no partial write emitted.

Verification
REQ-032 Push {5, 0xDEADBEEF} at edge 0, stall 0 -> reg_write = 1, write_register = 5, write_data = 0xDEADBEEF in the cycle after edge 1 only; count returns to 0.
REQ-033 Stall = 1, push 5 requests {1..5, data = index} -> in_ready = 0 after 4 pushes, count = 4; release stall -> writes 1, 2, 3, 4 on 4 consecutive cycles, then in_ready = 1.
REQ-034 Queue {7, 0x11} then {7, 0x22}, lookup_register_1 = 7 -> hit 1, data 0x22; after first pop still 0x22; after both drained and output stage idle -> hit 0, data 0.
REQ-035 Push {0, 0x1234} -> handshake completes, count stays 0, no reg_write; lookup of 0 -> hit 0.
REQ-036 Steady push and pop each cycle at count = 2 -> count constant, write order matches push order across pointer wrap (at least 10 entries).
REQ-037 Assert reset_n low while count = 3 and reg_write = 1 -> reg_write, count, write_register and write_data read 0 before the next edge; in_ready = 1 after release.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue
//   Small FIFO between an execution unit and the register file write port.
//   Requests {register, data} are buffered and drained one per cycle into a
//   registered output stage that drives the register file write strobe.
//   Pending writes (queue plus the output stage) are visible to two
//   combinational forwarding lookups, which return the youngest pending data.
//
// Ports
//   clock, reset_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready               : producer handshake
//   in_register, in_data            : offered write request
//   stall                           : blocks draining into the register file
//   reg_write, write_register/data  : register file write port (registered)
//   lookup_register_1/2             : forwarding query indices
//   lookup_hit_1/2, lookup_data_1/2 : forwarding results (data 0 on miss)
//   count                           : entries queued, output stage excluded
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_register,
   input  logic [31:0]              in_data,
   input  logic                     stall,
   output logic                     reg_write,
   output logic [4:0]               write_register,
   output logic [31:0]              write_data,
   input  logic [4:0]               lookup_register_1,
   input  logic [4:0]               lookup_register_2,
   output logic                     lookup_hit_1,
   output logic                     lookup_hit_2,
   output logic [31:0]              lookup_data_1,
   output logic [31:0]              lookup_data_2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    r_q_reg  [DEPTH];
   logic [31:0]   r_q_data [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_wr_en;
   logic [4:0]    r_wr_reg;
   logic [31:0]   r_wr_data;

   logic          w_ready;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;

   // Ready depends on registered count only, so a full queue refuses a push
   // even on an edge where it also pops.
   assign w_ready  = (r_count < CW'(DEPTH));
   assign w_accept = in_valid & w_ready;
   // Writes to register 0 are acknowledged but dropped.
   assign w_push   = w_accept & (in_register != 5'd0);
   assign w_pop    = ~stall & (r_count != '0);

   // Entry storage needs no reset; validity is tracked by head/count.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_q_reg[r_tail]  <= in_register;
         r_q_data[r_tail] <= in_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_reg  <= '0;
         r_wr_data <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // Output stage strobes for one cycle per pop; index/data hold otherwise.
         r_wr_en <= w_pop;
         if (w_pop) begin
            r_wr_reg  <= r_q_reg[r_head];
            r_wr_data <= r_q_data[r_head];
         end
      end
   end

   // Forwarding: output stage is the oldest pending write, then queue entries
   // from head (oldest) to tail-1 (youngest); later matches override earlier.
   logic [1:0][4:0]  w_lk_reg;
   logic [1:0]       w_lk_hit;
   logic [1:0][31:0] w_lk_data;

   assign w_lk_reg = {lookup_register_2, lookup_register_1};

   always_comb begin
      w_lk_hit  = '0;
      w_lk_data = '0;
      for (int p = 0; p < 2; p++) begin
         if (w_lk_reg[p] != 5'd0) begin
            if (r_wr_en && (r_wr_reg == w_lk_reg[p])) begin
               w_lk_hit[p]  = 1'b1;
               w_lk_data[p] = r_wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
               if ((CW'(i) < r_count) &&
                   (r_q_reg[r_head + AW'(i)] == w_lk_reg[p])) begin
                  w_lk_hit[p]  = 1'b1;
                  w_lk_data[p] = r_q_data[r_head + AW'(i)];
               end
            end
         end
      end
   end

   assign in_ready       = w_ready;
   assign reg_write      = r_wr_en;
   assign write_register = r_wr_reg;
   assign write_data     = r_wr_data;
   assign lookup_hit_1   = w_lk_hit[0];
   assign lookup_hit_2   = w_lk_hit[1];
   assign lookup_data_1  = w_lk_data[0];
   assign lookup_data_2  = w_lk_data[1];
   assign count          = r_count;

endmodule
